// File: rtl/periodic_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module     : periodic_irq_pkg
// Description: Shared types and constants for the periodic interrupt
//              generator: channel control word layout, register select
//              encoding and counter mode values.
// Revision   : 1.0 - initial release
// ============================================================================
package periodic_irq_pkg;

    // Control word as stored per channel and as written through wr_data[2:0].
    typedef struct packed {
        logic mask;     // gates ei_req only
        logic mode;     // MODE_PERIODIC / MODE_ONESHOT
        logic enable;   // counter running
    } ctrl_t;

    // Register select shared by the write and read paths.
    typedef enum logic {
        SEL_PERIOD = 1'b0,
        SEL_CTRL   = 1'b1
    } wr_sel_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/periodic_irq_channel.sv
`default_nettype none
// ============================================================================
// Module     : periodic_irq_channel
// Description: One interrupt channel: period counter, period register,
//              control register, pending flag and saturating missed-tick
//              counter.
// Ports      : clk, reset (async, active-high)
//              wr_period / wr_ctrl - decoded single-cycle write strobes
//              wr_data             - write data (ctrl uses [2:0])
//              ack                 - clears pending and miss
//              period, ctrl, pending, miss - register state for read-back
// Revision   : 1.0 - initial release
// ============================================================================
module periodic_irq_channel
    import periodic_irq_pkg::*;
#(
    parameter int         CNT_W        = 24,
    parameter int         MISS_W       = 4,
    parameter int         RESET_PERIOD = 6249,
    parameter logic [2:0] RESET_CTRL   = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_period,
    input  logic              wr_ctrl,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              ack,
    output logic [CNT_W-1:0]  period,
    output logic [2:0]        ctrl,
    output logic              pending,
    output logic [MISS_W-1:0] miss
);

    localparam logic [CNT_W-1:0]  c_reset_period = CNT_W'(RESET_PERIOD);
    localparam logic [CNT_W-1:0]  c_cnt_one      = CNT_W'(1);
    localparam logic [MISS_W-1:0] c_miss_one     = MISS_W'(1);

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_period;
    ctrl_t             r_ctrl;
    logic              r_pending;
    logic [MISS_W-1:0] r_miss;

    logic [CNT_W-1:0]  w_cnt_nxt;
    ctrl_t             w_ctrl_nxt;
    ctrl_t             w_new_ctrl;
    logic              w_tick;

    assign w_new_ctrl = ctrl_t'(wr_data[2:0]);

    // Tick compares against the period held before any same-cycle write.
    assign w_tick = r_ctrl.enable && (r_cnt == r_period);

    // Later assignments take priority: a period write or a start/stop via
    // ctrl always restarts the count from zero.
    always_comb begin
        w_cnt_nxt = r_cnt + c_cnt_one;
        if (!r_ctrl.enable) begin
            w_cnt_nxt = '0;
        end
        if (w_tick) begin
            w_cnt_nxt = '0;
        end
        if (wr_ctrl && (!w_new_ctrl.enable || !r_ctrl.enable)) begin
            w_cnt_nxt = '0;
        end
        if (wr_period) begin
            w_cnt_nxt = '0;
        end
    end

    // One-shot self-disable happens on the tick edge, but a ctrl write in
    // the same cycle takes precedence.
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_tick && (r_ctrl.mode == MODE_ONESHOT)) begin
            w_ctrl_nxt.enable = 1'b0;
        end
        if (wr_ctrl) begin
            w_ctrl_nxt = w_new_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_period <= c_reset_period;
            r_ctrl   <= ctrl_t'(RESET_CTRL);
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_ctrl <= w_ctrl_nxt;
            if (wr_period) begin
                r_period <= wr_data;
            end
        end
    end

    // A tick coinciding with ack keeps pending set and leaves miss alone;
    // only an un-acked tick on an already pending channel counts as missed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_miss    <= '0;
        end else if (w_tick) begin
            r_pending <= 1'b1;
            if (r_pending && !ack && (r_miss != '1)) begin
                r_miss <= r_miss + c_miss_one;
            end
        end else if (ack) begin
            r_pending <= 1'b0;
            r_miss    <= '0;
        end
    end

    assign period  = r_period;
    assign ctrl    = r_ctrl;
    assign pending = r_pending;
    assign miss    = r_miss;

endmodule
`default_nettype wire

// File: rtl/periodic_irq_gen.sv
`default_nettype none
// ============================================================================
// Module     : periodic_irq_gen
// Description: Multi-channel programmable periodic interrupt generator.
//              Decodes register writes to N_CH channels, multiplexes
//              register read-back and drives the registered MCU ei_req.
// Ports      : clk, reset (async, active-high)
//              wr_en/wr_ch/wr_sel/wr_data - register write port
//              ack[N_CH]                  - per-channel pending clear
//              rd_ch/rd_sel -> rd_data    - combinational read port
//              pending[N_CH]              - latched expiry flags
//              ei_req                     - OR of unmasked pending, registered
// Revision   : 1.0 - initial release
// ============================================================================
module periodic_irq_gen
    import periodic_irq_pkg::*;
#(
    parameter int         N_CH         = 4,
    parameter int         CNT_W        = 24,
    parameter int         MISS_W       = 4,
    parameter int         RESET_PERIOD = 6249,
    parameter logic [2:0] RESET_CTRL   = 3'b001
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [2:0]                wr_ch,
    input  logic                      wr_sel,
    input  logic [CNT_W-1:0]          wr_data,
    input  logic [N_CH-1:0]           ack,
    input  logic [2:0]                rd_ch,
    output logic [CNT_W+MISS_W+3:0]   rd_data,
    input  logic                      rd_sel,
    output logic [N_CH-1:0]           pending,
    output logic                      ei_req
);

    logic [CNT_W-1:0]  w_period [N_CH];
    logic [2:0]        w_ctrl   [N_CH];
    logic [MISS_W-1:0] w_miss   [N_CH];
    logic [N_CH-1:0]   w_mask;
    logic              r_ei_req;

    // wr_ch is only ever matched against real channel indices, so writes
    // addressed beyond N_CH fall through with no effect.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [2:0] c_rst_ctrl = (i == 0) ? RESET_CTRL : 3'b000;

        logic w_hit;
        assign w_hit = wr_en && (wr_ch == 3'(i));

        periodic_irq_channel #(
            .CNT_W        (CNT_W),
            .MISS_W       (MISS_W),
            .RESET_PERIOD (RESET_PERIOD),
            .RESET_CTRL   (c_rst_ctrl)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .wr_period (w_hit && (wr_sel == SEL_PERIOD)),
            .wr_ctrl   (w_hit && (wr_sel == SEL_CTRL)),
            .wr_data   (wr_data),
            .ack       (ack[i]),
            .period    (w_period[i]),
            .ctrl      (w_ctrl[i]),
            .pending   (pending[i]),
            .miss      (w_miss[i])
        );

        assign w_mask[i] = w_ctrl[i][2];
    end

    // Unmatched rd_ch (>= N_CH) leaves the all-zero default.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == 3'(i)) begin
                if (rd_sel == SEL_CTRL) begin
                    rd_data = {{CNT_W{1'b0}}, w_miss[i], pending[i], w_ctrl[i]};
                end else begin
                    rd_data = {{(MISS_W+4){1'b0}}, w_period[i]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ei_req <= 1'b0;
        end else begin
            r_ei_req <= |(pending & ~w_mask);
        end
    end

    assign ei_req = r_ei_req;

endmodule
`default_nettype wire

// File: tb/tb_periodic_irq_gen.sv
`default_nettype none
// ============================================================================
// Module     : tb_periodic_irq_gen
// Description: Directed self-checking bench for periodic_irq_gen. Expected
//              values are queued as stimulus is applied and compared when
//              the corresponding DUT output is sampled.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_periodic_irq_gen;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 24;
    localparam int MISS_W = 4;
    localparam int RD_W   = CNT_W + MISS_W + 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [2:0]        wr_ch;
    logic              wr_sel;
    logic [CNT_W-1:0]  wr_data;
    logic [N_CH-1:0]   ack;
    logic [2:0]        rd_ch;
    logic              rd_sel;
    logic [RD_W-1:0]   rd_data;
    logic [N_CH-1:0]   pending;
    logic              ei_req;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];

    periodic_irq_gen #(
        .N_CH         (N_CH),
        .CNT_W        (CNT_W),
        .MISS_W       (MISS_W),
        .RESET_PERIOD (6249),
        .RESET_CTRL   (3'b001)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .ack     (ack),
        .rd_ch   (rd_ch),
        .rd_data (rd_data),
        .rd_sel  (rd_sel),
        .pending (pending),
        .ei_req  (ei_req)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $error("FAIL sb_empty: observed 0x%0h required an expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_errors++;
                $error("FAIL %s: observed 0x%0h required 0x%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic sel, input logic [CNT_W-1:0] data);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_sel  = sel;
        wr_data = data;
        step(1);
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic do_ack(input logic [N_CH-1:0] m);
        ack = m;
        step(1);
        ack = '0;
    endtask

    task automatic rd(input logic [2:0] ch, input logic sel, output logic [31:0] v);
        rd_ch  = ch;
        rd_sel = sel;
        #1;
        v = rd_data;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_sel = 1'b0;
        wr_data = '0; ack = '0; rd_ch = '0; rd_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ---- 1: reset defaults, ch0 free-runs at 6250 cycles ----
        expect_val("rst_period0", 32'd6249); rd(3'd0, 1'b0, v); check(v);
        expect_val("rst_ctrl0", 32'h01);     rd(3'd0, 1'b1, v); check(v);
        expect_val("rst_ctrl1", 32'h00);     rd(3'd1, 1'b1, v); check(v);
        expect_val("rst_pending", 32'h0);    check(32'(pending));
        expect_val("rst_ei", 32'h0);         check(32'(ei_req));
        expect_val("t1_pre_tick", 32'h0);
        step(6249);                          check(32'(pending));
        expect_val("t1_tick", 32'h1);
        expect_val("t1_ei_lag", 32'h0);
        step(1);                             check(32'(pending)); check(32'(ei_req));
        expect_val("t1_ei_rise", 32'h1);
        step(1);                             check(32'(ei_req));
        expect_val("t1_ack_pend", 32'h0);
        expect_val("t1_ack_ei_hold", 32'h1);
        do_ack(4'b0001);                     check(32'(pending)); check(32'(ei_req));
        expect_val("t1_ei_fall", 32'h0);
        step(1);                             check(32'(ei_req));
        expect_val("t1_pre_tick2", 32'h0);
        step(6246);                          check(32'(pending));
        expect_val("t1_tick2", 32'h1);
        expect_val("t1_rd2", 32'h09);
        step(1);                             check(32'(pending)); rd(3'd0, 1'b1, v); check(v);
        wr(3'd0, 1'b1, 24'd0);
        do_ack(4'b0001);
        expect_val("t1_quiet_ei", 32'h0);
        step(1);                             check(32'(ei_req));

        // ---- 2: ch1 period 9, ack three cycles after each tick ----
        wr(3'd1, 1'b0, 24'd9);
        wr(3'd1, 1'b1, 24'd1);
        expect_val("t2_pre", 32'h0);
        step(9);                             check(32'(pending));
        expect_val("t2_tick", 32'h2);
        step(1);                             check(32'(pending));
        expect_val("t2_ei", 32'h1);
        step(1);                             check(32'(ei_req));
        step(1);
        expect_val("t2_ack", 32'h0);
        do_ack(4'b0010);                     check(32'(pending));
        expect_val("t2_ei_fall", 32'h0);
        step(1);                             check(32'(ei_req));
        expect_val("t2_pre2", 32'h0);
        step(5);                             check(32'(pending));
        expect_val("t2_tick2", 32'h2);
        expect_val("t2_miss0", 32'h09);
        step(1);                             check(32'(pending)); rd(3'd1, 1'b1, v); check(v);
        expect_val("t2_ei2", 32'h1);
        step(1);                             check(32'(ei_req));
        wr(3'd1, 1'b1, 24'd0);
        do_ack(4'b0010);

        // ---- 3: ch2 period 4 un-acked, miss saturates ----
        wr(3'd2, 1'b0, 24'd4);
        wr(3'd2, 1'b1, 24'd1);
        expect_val("t3_sat", 32'hF9);
        expect_val("t3_ei", 32'h1);
        step(100);                           rd(3'd2, 1'b1, v); check(v); check(32'(ei_req));
        expect_val("t3_ack_clr", 32'h01);
        do_ack(4'b0100);                     rd(3'd2, 1'b1, v); check(v);
        wr(3'd2, 1'b1, 24'd0);
        do_ack(4'b0100);

        // ---- 4: ch3 one-shot, period 7 ----
        wr(3'd3, 1'b0, 24'd7);
        wr(3'd3, 1'b1, 24'd3);
        expect_val("t4_pre", 32'h0);
        step(7);                             check(32'(pending));
        expect_val("t4_tick", 32'h8);
        expect_val("t4_en_clr", 32'h0A);
        step(1);                             check(32'(pending)); rd(3'd3, 1'b1, v); check(v);
        expect_val("t4_no_retick", 32'h0A);
        step(16);                            rd(3'd3, 1'b1, v); check(v);
        do_ack(4'b1000);

        // ---- 5: masked ch1, period 2 ----
        wr(3'd1, 1'b0, 24'd2);
        wr(3'd1, 1'b1, 24'd5);
        expect_val("t5_pend", 32'h2);
        step(3);                             check(32'(pending));
        expect_val("t5_ei_masked", 32'h0);
        step(1);                             check(32'(ei_req));
        expect_val("t5_ei_masked2", 32'h0);
        expect_val("t5_miss_masked", 32'h2D);
        step(5);                             check(32'(ei_req)); rd(3'd1, 1'b1, v); check(v);
        wr(3'd1, 1'b1, 24'd1);
        expect_val("t5_unmask_lag", 32'h0);  check(32'(ei_req));
        expect_val("t5_unmask_ei", 32'h1);
        step(1);                             check(32'(ei_req));
        wr(3'd1, 1'b1, 24'd0);
        do_ack(4'b0010);

        // ---- 6a: ack coincident with tick ----
        wr(3'd2, 1'b1, 24'd1);
        expect_val("t6_first_tick", 32'h4);
        step(5);                             check(32'(pending));
        step(4);
        ack = 4'b0100;
        step(1);
        ack = '0;
        expect_val("t6_ack_tick_pend", 32'h4);
        expect_val("t6_ack_tick_miss", 32'h09);
        check(32'(pending));                 rd(3'd2, 1'b1, v); check(v);
        wr(3'd2, 1'b1, 24'd0);
        do_ack(4'b0100);

        // ---- 6b: out-of-range channel writes and reads ----
        wr(3'd5, 1'b0, 24'd123);
        wr(3'd5, 1'b1, 24'd7);
        begin
            logic [31:0] exp_per [N_CH];
            logic [31:0] exp_ctl [N_CH];
            exp_per = '{32'd6249, 32'd2, 32'd4, 32'd7};
            exp_ctl = '{32'h00, 32'h00, 32'h00, 32'h02};
            for (int i = 0; i < N_CH; i++) begin
                expect_val($sformatf("t6_oor_period%0d", i), exp_per[i]);
                rd(3'(i), 1'b0, v); check(v);
                expect_val($sformatf("t6_oor_ctrl%0d", i), exp_ctl[i]);
                rd(3'(i), 1'b1, v); check(v);
            end
        end
        expect_val("t6_rd_oor_p", 32'h0);    rd(3'd5, 1'b0, v); check(v);
        expect_val("t6_rd_oor_c", 32'h0);    rd(3'd7, 1'b1, v); check(v);
        expect_val("t6_oor_pend", 32'h0);    check(32'(pending));

        // ---- 6c: asynchronous reset mid-count ----
        wr(3'd2, 1'b0, 24'd0);
        wr(3'd2, 1'b1, 24'd1);
        expect_val("t6_pre_rst_ei", 32'h1);
        step(3);                             check(32'(ei_req));
        #2 reset = 1'b1;
        #1;
        expect_val("t6_rst_ei", 32'h0);      check(32'(ei_req));
        expect_val("t6_rst_pend", 32'h0);    check(32'(pending));
        expect_val("t6_rst_period2", 32'd6249); rd(3'd2, 1'b0, v); check(v);
        expect_val("t6_rst_ctrl0", 32'h01);  rd(3'd0, 1'b1, v); check(v);
        expect_val("t6_rst_ctrl2", 32'h00);  rd(3'd2, 1'b1, v); check(v);
        step(1);
        reset = 1'b0;

        expect_val("sb_drained", 32'h0);
        check(32'(sb_q.size() - 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
